// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a WIDTH-bit addition through an external registered 4-bit adder,
// one nibble per cycle, chaining the adder's registered carry back in.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [NIB_W-1:0] add_a,
  output logic [NIB_W-1:0] add_b,
  output logic             add_cin,
  input  logic [NIB_W-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t state, state_next;
  logic [IDX_W-1:0] idx;
  logic [NIB-1:0][NIB_W-1:0] opa_q, opb_q, sum_q;
  logic cin_q, cout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a   = opa_q[idx];
        add_b   = opb_q[idx];
        // From nibble 1 on, the adder's registered carry feeds straight back.
        add_cin = (idx == '0) ? cin_q : add_cout;
        if (idx == LAST) state_next = DRAIN;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cin_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa_q <= in_a;
            opb_q <= in_b;
            cin_q <= in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          // The adder returns nibble idx-1 while nibble idx is being driven.
          if (idx != '0) sum_q[idx - IDX_W'(1)] <= add_sum;
          if (idx != LAST) idx <= idx + IDX_W'(1);
        end
        DRAIN: begin
          sum_q[LAST] <= add_sum;
          cout_q      <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench: DUT plus registered 4-bit adder stage, checked against a plain
// arithmetic reference of the handshake timing and the wide sum.
module tb_nibble_serial_add_ctrl;

  localparam int NIB16 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // 16-bit instance and its adder stage
  logic        in_valid = 1'b0, in_ready, in_cin = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout, out_valid, out_ready = 1'b0, out_cout;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always @(posedge clk or negedge rst)
    if (!rst) {add_cout, add_sum} <= 5'd0;
    else      {add_cout, add_sum} <= add_a + add_b + add_cin;

  // 8-bit instance and its adder stage
  logic       v8 = 1'b0, rdy8, c8 = 1'b0, ov8, or8 = 1'b1, co8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic [3:0] aa8, ab8, as8;
  logic       ac8, acout8;

  nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8), .in_cin(c8),
    .add_a(aa8), .add_b(ab8), .add_cin(ac8),
    .add_sum(as8), .add_cout(acout8),
    .out_valid(ov8), .out_ready(or8),
    .out_sum(s8), .out_cout(co8)
  );

  always @(posedge clk or negedge rst)
    if (!rst) {acout8, as8} <= 5'd0;
    else      {acout8, as8} <= aa8 + ab8 + ac8;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: one outstanding op, result due NIB+2 posedge counts
  // after the accepting negedge, value = 17-bit a+b+cin.
  logic        pending = 1'b0;
  int          acc_cyc = 0;
  logic [16:0] exp_res = '0;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic        exp_c = 1'b0;

  always @(negedge clk) begin
    logic exp_valid;
    if (!rst) begin
      pending = 1'b0;
    end else begin
      exp_valid = pending && (cyc - acc_cyc >= NIB16 + 2);
      check("in_ready", in_ready, !pending);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        check("out_sum", out_sum, exp_res[15:0]);
        check("out_cout", out_cout, exp_res[16]);
      end
      if (!pending || exp_valid) begin
        check("idle_add_a", add_a, 4'h0);
        check("idle_add_b", add_b, 4'h0);
        check("idle_add_cin", add_cin, 1'b0);
      end
      if (exp_valid && out_ready) begin
        $display("op %h + %h + %0d -> cout=%0d sum=%h", exp_a, exp_b, exp_c, out_cout, out_sum);
        pending = 1'b0;
      end else if (!pending && in_valid) begin
        pending = 1'b1;
        acc_cyc = cyc;
        exp_a   = in_a;
        exp_b   = in_b;
        exp_c   = in_cin;
        exp_res = {1'b0, in_a} + {1'b0, in_b} + {16'd0, in_cin};
      end
    end
  end

  // Random out_ready during the random phase only.
  logic rand_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom % 3) != 0;
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output int lat);
    int acc, n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    wait_accept();
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
    lat = cyc - acc - 1;
    s = out_sum;
    co = out_cout;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom % 6)
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] s, held_s;
    logic co, held_co;
    int lat, n;

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 16'h0);
    check("rst_add_a", add_a, 4'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst8_in_ready", rdy8, 1'b1);

    out_ready = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0, s, co, lat);
    check("d1_sum", s, 16'h5555);
    check("d1_cout", co, 1'b0);
    check("d1_latency", lat, 5);
    run_op(16'hFFFF, 16'h0001, 1'b0, s, co, lat);
    check("d2_sum", s, 16'h0000);
    check("d2_cout", co, 1'b1);
    check("d2_latency", lat, 5);
    run_op(16'h0000, 16'h0000, 1'b1, s, co, lat);
    check("d3_sum", s, 16'h0001);
    check("d3_cout", co, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, s, co, lat);
    check("d4_sum", s, 16'h0000);
    check("d4_cout", co, 1'b1);

    // Backpressure in DONE with a competing request that must be ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    run_op(16'h0F0F, 16'h0101, 1'b1, held_s, held_co, lat);
    check("bp_sum", held_s, 16'h1011);
    check("bp_cout", held_co, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i >= 3 && i < 7); in_a = 16'hAAAA; in_b = 16'h5555;
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_sum", out_sum, held_s);
      check("bp_hold_cout", out_cout, held_co);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_last_valid", out_valid, 1'b1);
    @(negedge clk);
    check("bp_released", out_valid, 1'b0);
    check("bp_ready_back", in_ready, 1'b1);

    // Reset while RUN is on nibble 2.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0;
    wait_accept();
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("run2_add_a", add_a, 4'h2);
    check("run2_add_b", add_b, 4'h3);
    check("run2_add_cin", add_cin, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_sum", out_sum, 16'h0);
    check("mid_rst_out_cout", out_cout, 1'b0);
    check("mid_rst_add_a", add_a, 4'h0);
    check("mid_rst_add_b", add_b, 4'h0);
    check("mid_rst_add_cin", add_cin, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, s, co, lat);
    check("post_rst_sum", s, 16'h0100);
    check("post_rst_cout", co, 1'b0);
    check("post_rst_latency", lat, 5);

    // Random phase.
    rand_mode = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      n = $urandom_range(0, 3);
      repeat (n) @(posedge clk);
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = pick16(); in_b = pick16(); in_cin = 1'($urandom);
      wait_accept();
      @(posedge clk); #1 in_valid = 1'b0;
    end
    n = 0;
    while (pending && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pending) check("drain_timeout", 32'd0, 32'd1);
    rand_mode = 1'b0;

    // WIDTH=8 instance.
    @(posedge clk); #1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready", rdy8, 1'b1);
    lat = cyc;
    @(posedge clk); #1 v8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w8_valid", ov8, 1'b1);
    check("w8_latency", cyc - lat - 1, 3);
    check("w8_sum", s8, 8'hFF);
    check("w8_cout", co8, 1'b1);
    $display("op8 ff + ff + 1 -> cout=%0d sum=%h", co8, s8);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Nibble-serial sequencer for WIDTH-bit additions on the team's registered 4-bit adder stage (inputs A/B/carryin, registered sum/carryout, one-cycle latency). Accepts a wide operand pair over a valid/ready handshake. Drives one nibble pair per cycle into the adder, least-significant first, and chains the adder's registered carryout back into its carryin. Collects the returned sum nibbles into a WIDTH-bit result, presented on a valid/ready output.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8
- NIB (derived), WIDTH/4, number of nibble steps
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block idle, operand pair accepted this cycle if in_valid
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry into nibble 0
- add_a  output  4  nibble A to adder stage
- add_b  output  4  nibble B to adder stage
- add_cin  output  1  carry to adder stage
- add_sum  input  4  registered sum from adder stage
- add_cout  input  1  registered carryout from adder stage
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer takes result
- out_sum  output  WIDTH  assembled result
- out_cout  output  1  carry out of nibble NIB-1

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid: latch in_a, in_b, in_cin into opa_q, opb_q, cin_q; idx<=0; go RUN.
- RUN, step idx:
  - Drive add_a=opa_q[4*idx+:4] and add_b=opb_q[4*idx+:4].
  - Drive add_cin=cin_q when idx==0, else add_cout (combinational pass-through of the adder's registered carry).
  - On each edge with idx≥1, capture add_sum into out_sum nibble idx-1.
  - At idx==NIB-1, go DRAIN; otherwise increment idx.
- DRAIN:
  - Drive add_a=add_b=0 and add_cin=0.
  - Capture add_sum into nibble NIB-1 and add_cout into out_cout.
  - Go DONE.
- DONE: out_valid=1. out_sum and out_cout are stable until out_valid && out_ready, then go IDLE.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- in_valid is ignored outside IDLE (in_ready=0).
- Arithmetic result: {out_cout,out_sum} = in_a + in_b + in_cin, mod 2^(WIDTH+1).
- The adder stage shares clk and rst. A reset clears both blocks together.

## Timing
- Reset values: in_ready=1 (after release), out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0, add_cin=0, state=IDLE, idx=0.
- Accept at edge E0. Nibble k is driven in cycle E_k..E_{k+1} and registered by the adder at E_{k+1}. The controller captures it at E_{k+2}.
- out_valid rises after E_{NIB+1}. Accept-to-valid latency is NIB+1 cycles (5 for WIDTH=16).
- With out_ready held high, out_valid is high for exactly one cycle. in_ready returns on the next cycle.
- Throughput: one operation per NIB+3 cycles at most. Back-to-back acceptance in the DONE→IDLE cycle is not supported.
- Full-width carry ripple (e.g. all-ones + 1) costs no extra cycles. The carry moves one nibble per cycle.
- Reset mid-RUN/DRAIN/DONE:
  - Aborts immediately and asynchronously.
  - The partial result is discarded; out_valid drops at once.
  - The first accept after release starts a clean operation.
- out_ready while not out_valid: ignored.

## Structure
- Package nibble_add_pkg holds:
  - NIB_W=4;
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - a function returning NIB for a given WIDTH.
- Single module with no sub-modules.
- The adder stage is a separate neighbouring instance; the test bench instantiates both and connects add_* ports.
- The idx width is $clog2(NIB).
- Elaboration-time check: WIDTH%4==0 and WIDTH≥8.

## Test plan
- 0x1234+0x4321, cin=0 -> out_sum=0x5555, out_cout=0, out_valid 5 cycles after accept.
- 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1; carry rippled through all four nibbles.
- 0x0000+0x0000, cin=1 -> out_sum=0x0001, out_cout=0; also 0x8000+0x8000 -> 0x0000, out_cout=1.
- Backpressure: out_ready low 10 cycles in DONE -> out_sum/out_cout stable, in_ready=0, a new in_valid is ignored; the first out_ready=1 completes the transfer.
- rst asserted at RUN idx=2 -> all outputs at reset values immediately. After release, 0x00FF+0x0001 -> 0x0100, out_cout=0.
- Random: 1000 operand pairs with random in_valid/out_ready gaps, checked against a 17-bit reference sum. WIDTH=8 regression: 0xFF+0xFF+1 -> 0xFF, out_cout=1, latency 3.
